// File: rtl/axis_window_pkg.sv
// rtl/axis_window_pkg.sv - state enum and result-word field layout for axis_window_peak
package axis_window_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

`ifdef AXIS_WINDOW_PEAK_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  // Result word, low to high: peak, peak index, last (length-1), optional sum.
  function automatic int peak_lsb();
    return 0;
  endfunction

  function automatic int idx_lsb(int dw);
    return dw;
  endfunction

  function automatic int last_lsb(int dw, int cw);
    return dw + cw;
  endfunction

  function automatic int sum_lsb(int dw, int cw);
    return dw + 2 * cw;
  endfunction

  function automatic int sum_width(int dw, int cw);
    return dw + cw;
  endfunction

  function automatic int m_width(int dw, int cw, bit sum_en);
    return sum_en ? (2 * dw + 3 * cw) : (dw + 2 * cw);
  endfunction

endpackage

// File: rtl/axis_window_result_buf.sv
// rtl/axis_window_result_buf.sv - one-entry result holding register with sticky drop flag
module axis_window_result_buf #(
  parameter int WIDTH = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             commit,
  input  logic [WIDTH-1:0] commit_data,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             overflow
);

  logic can_load;

  // A slot freed by a same-cycle consume can take the new result immediately.
  assign can_load = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      if (commit && can_load) begin
        m_axis_tdata  <= commit_data;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (commit && !can_load) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_window_peak.sv
// rtl/axis_window_peak.sv - per-window signed peak/index/length summariser; AXIS_WINDOW_PEAK_SUM_EN adds a sample sum
module axis_window_peak
  import axis_window_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CNTR_WIDTH = 8,
  localparam int M_WIDTH = m_width(DATA_WIDTH, CNTR_WIDTH, SUM_EN)
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [CNTR_WIDTH-1:0]        cfg,
  input  logic signed [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic [M_WIDTH-1:0]           m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         overflow
);

  state_t                       state, state_nxt;
  logic [CNTR_WIDTH-1:0]        limit, count, idx;
  logic signed [DATA_WIDTH-1:0] peak;
  logic                         start, step, commit;
  logic [M_WIDTH-1:0]           commit_data;

  // A forced close both commits the full window and opens a new one on this sample.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          start     = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!s_axis_tvalid) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else if (count == limit) begin
          commit = 1'b1;
          start  = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      limit <= '0;
      count <= '0;
      idx   <= '0;
      peak  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        limit <= cfg;
        count <= '0;
        idx   <= '0;
        peak  <= s_axis_tdata;
      end else if (step) begin
        count <= count + 1'b1;
        if (s_axis_tdata > peak) begin
          peak <= s_axis_tdata;
          idx  <= count + 1'b1;
        end
      end
    end
  end

`ifdef AXIS_WINDOW_PEAK_SUM_EN
  logic signed [DATA_WIDTH+CNTR_WIDTH-1:0] sum;
  logic signed [DATA_WIDTH+CNTR_WIDTH-1:0] sample_ext;

  assign sample_ext = {{CNTR_WIDTH{s_axis_tdata[DATA_WIDTH-1]}}, s_axis_tdata};

  always_ff @(posedge aclk) begin
    if (areset) begin
      sum <= '0;
    end else if (start) begin
      sum <= sample_ext;
    end else if (step) begin
      sum <= sum + sample_ext;
    end
  end

  assign commit_data = {sum, count, idx, peak};
`else
  assign commit_data = {count, idx, peak};
`endif

  axis_window_result_buf #(
    .WIDTH(M_WIDTH)
  ) u_result_buf (
    .aclk          (aclk),
    .areset        (areset),
    .commit        (commit),
    .commit_data   (commit_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .overflow      (overflow)
  );

endmodule

// File: tb/tb_axis_window_peak.sv
// tb/tb_axis_window_peak.sv - scoreboard bench for axis_window_peak
module tb_axis_window_peak;

  localparam int DW = 16;
  localparam int CW = 8;
`ifdef AXIS_WINDOW_PEAK_SUM_EN
  localparam int MW = 2 * DW + 3 * CW;
`else
  localparam int MW = DW + 2 * CW;
`endif

  logic                 aclk = 1'b0;
  logic                 areset = 1'b1;
  logic [CW-1:0]        cfg = '0;
  logic signed [DW-1:0] s_tdata = '0;
  logic                 s_tvalid = 1'b0;
  logic [MW-1:0]        m_tdata;
  logic                 m_tvalid;
  logic                 m_tready = 1'b0;
  logic                 overflow;

  int            checks = 0;
  int            fails = 0;
  logic [MW-1:0] exp_q[$];
  logic [MW-1:0] mon_exp;

  axis_window_peak #(
    .DATA_WIDTH(DW),
    .CNTR_WIDTH(CW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg           (cfg),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .overflow      (overflow)
  );

  always #5 aclk = ~aclk;

  function automatic logic [MW-1:0] mk(int pk, int ix, int ls, int sm);
    logic [MW-1:0] w;
    w = '0;
    w[15:0]  = pk[15:0];
    w[23:16] = ix[7:0];
    w[31:24] = ls[7:0];
`ifdef AXIS_WINDOW_PEAK_SUM_EN
    w[55:32] = sm[23:0];
`else
    if (sm == 0) w[0] = w[0];
`endif
    return w;
  endfunction

  task automatic drive(input bit v, input int d);
    s_tvalid = v;
    s_tdata  = 16'(d);
    @(posedge aclk);
    #1;
  endtask

  // Scoreboard: every handshaken beat must match the oldest expected word.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected got=%h expected=none", m_tdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (m_tdata !== mon_exp) begin
          fails++;
          $display("FAIL result_word got=%h expected=%h", m_tdata, mon_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    areset   = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got=%b expected=0", m_tvalid); end
    checks++;
    if (m_tdata !== '0) begin fails++; $display("FAIL reset_tdata got=%h expected=0", m_tdata); end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
    areset = 1'b0;
    drive(0, 0);
  endtask

  task automatic test_natural_close();
    cfg      = 8'd7;
    m_tready = 1'b1;
    exp_q.push_back(mk(9, 2, 3, 19));
    drive(1, 3);
    drive(1, -2);
    drive(1, 9);
    drive(1, 9);
    checks++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL natural_early_valid got=%b expected=0", m_tvalid); end
    drive(0, 0);
    checks++;
    if (m_tvalid !== 1'b1) begin fails++; $display("FAIL natural_latency got=%b expected=1", m_tvalid); end
    drive(0, 0);
    drive(0, 0);
    checks++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL natural_drain got=%b expected=0", m_tvalid); end
  endtask

  task automatic test_forced_close();
    cfg      = 8'd3;
    m_tready = 1'b1;
    exp_q.push_back(mk(3, 3, 3, 6));
    exp_q.push_back(mk(7, 3, 3, 22));
    exp_q.push_back(mk(9, 1, 1, 17));
    drive(1, 0);
    cfg = 8'd0;
    for (int i = 1; i < 4; i++) drive(1, i);
    cfg = 8'd3;
    drive(1, 4);
    checks++;
    if (m_tvalid !== 1'b1) begin fails++; $display("FAIL forced_latency_1 got=%b expected=1", m_tvalid); end
    for (int i = 5; i < 10; i++) begin
      drive(1, i);
      if (i == 8) begin
        checks++;
        if (m_tvalid !== 1'b1) begin fails++; $display("FAIL forced_latency_2 got=%b expected=1", m_tvalid); end
      end
    end
    drive(0, 0);
    checks++;
    if (m_tvalid !== 1'b1) begin fails++; $display("FAIL forced_tail_valid got=%b expected=1", m_tvalid); end
    drive(0, 0);
    drive(0, 0);
  endtask

  task automatic test_negative();
    cfg      = 8'd7;
    m_tready = 1'b1;
    exp_q.push_back(mk(-1, 1, 2, -14));
    drive(1, -5);
    drive(1, -1);
    drive(1, -8);
    drive(0, 0);
    drive(0, 0);
    drive(0, 0);
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL negative_overflow got=%b expected=0", overflow); end
  endtask

  task automatic test_overflow();
    cfg      = 8'd0;
    m_tready = 1'b0;
    drive(1, 5);
    drive(1, 6);
    checks++;
    if (m_tvalid !== 1'b1) begin fails++; $display("FAIL ovf_first_valid got=%b expected=1", m_tvalid); end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_early got=%b expected=0", overflow); end
    drive(0, 0);
    checks++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got=%b expected=1", overflow); end
    checks++;
    if (m_tdata !== mk(5, 0, 0, 5)) begin fails++; $display("FAIL ovf_held_data got=%h expected=%h", m_tdata, mk(5, 0, 0, 5)); end
    drive(1, 7);
    checks++;
    if (m_tdata !== mk(5, 0, 0, 5)) begin fails++; $display("FAIL ovf_still_held got=%h expected=%h", m_tdata, mk(5, 0, 0, 5)); end
    exp_q.push_back(mk(5, 0, 0, 5));
    exp_q.push_back(mk(7, 0, 0, 7));
    m_tready = 1'b1;
    drive(0, 0);
    checks++;
    if (m_tvalid !== 1'b1) begin fails++; $display("FAIL ovf_replace_valid got=%b expected=1", m_tvalid); end
    checks++;
    if (m_tdata !== mk(7, 0, 0, 7)) begin fails++; $display("FAIL ovf_replace_data got=%h expected=%h", m_tdata, mk(7, 0, 0, 7)); end
    drive(0, 0);
    drive(0, 0);
    checks++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got=%b expected=1", overflow); end
  endtask

  task automatic test_reset_mid_window();
    cfg      = 8'd7;
    m_tready = 1'b1;
    drive(1, 10);
    drive(1, 20);
    areset = 1'b1;
    drive(0, 0);
    checks++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_tvalid got=%b expected=0", m_tvalid); end
    checks++;
    if (m_tdata !== '0) begin fails++; $display("FAIL rstmid_tdata got=%h expected=0", m_tdata); end
    checks++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL rstmid_overflow got=%b expected=0", overflow); end
    areset = 1'b0;
    drive(0, 0);
    checks++;
    if (m_tvalid !== 1'b0) begin fails++; $display("FAIL rstmid_no_result got=%b expected=0", m_tvalid); end
    exp_q.push_back(mk(3, 2, 2, 6));
    drive(1, 1);
    drive(1, 2);
    drive(1, 3);
    drive(0, 0);
    drive(0, 0);
    drive(0, 0);
  endtask

  task automatic test_back_to_back();
    cfg      = 8'd7;
    m_tready = 1'b1;
    exp_q.push_back(mk(4, 0, 1, 5));
    exp_q.push_back(mk(8, 1, 2, 18));
    drive(1, 4);
    drive(1, 1);
    drive(0, 0);
    drive(1, 2);
    drive(1, 8);
    drive(1, 8);
    drive(0, 0);
    drive(0, 0);
    drive(0, 0);
  endtask

  initial begin
    test_reset();
    test_natural_close();
    test_forced_close();
    test_negative();
    test_overflow();
    test_reset_mid_window();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
